// File: rtl/envelope_gen.sv
// ADSR envelope generator: one step per sample tick, amplitude plus a one-cycle valid pulse per tick.
// Optional build macro ENVGEN_EXP_RELEASE_EN selects exponential release (step = (env >> rate[3:0]) + 1).
module envelope_gen #(
    parameter int C_WIDTH      = 16,
    parameter int C_RATE_WIDTH = 16
) (
    input  logic                    ctl_clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    gate,
    input  logic [C_RATE_WIDTH-1:0] attack_rate,
    input  logic [C_RATE_WIDTH-1:0] decay_rate,
    input  logic [C_WIDTH-1:0]      sustain_level,
    input  logic [C_RATE_WIDTH-1:0] release_rate,
    output logic [C_WIDTH-1:0]      env_out,
    output logic                    env_valid,
    output logic [2:0]              state,
    output logic                    busy
);

    localparam int EW = C_WIDTH + 1;
    localparam logic [EW-1:0] FULL_EXT = {1'b0, {C_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [C_WIDTH-1:0]   env_q, env_d;
    logic                 valid_q, valid_d;
    logic                 gate_q, gate_d;

    logic                 rise, fall;
    logic [EW-1:0]        env_ext;
    logic [EW-1:0]        atk_sum;
    logic [C_WIDTH-1:0]   atk_env;
    logic                 atk_done;
    logic [EW-1:0]        dec_floor;
    logic [C_WIDTH-1:0]   dec_env;
    logic                 dec_done;
    logic [EW-1:0]        rel_step;
    logic [C_WIDTH-1:0]   rel_env;
    logic                 rel_done;

`ifdef ENVGEN_EXP_RELEASE_EN
    logic unused_rel_bits;
    assign unused_rel_bits = ^release_rate[C_RATE_WIDTH-1:4];
`endif

    // All step candidates are computed one bit wider so saturation tests never see a wrapped value.
    always_comb begin
        env_ext = EW'(env_q);

        atk_sum = env_ext + EW'(attack_rate);
        if (atk_sum >= FULL_EXT) begin
            atk_env  = '1;
            atk_done = 1'b1;
        end else begin
            atk_env  = atk_sum[C_WIDTH-1:0];
            atk_done = 1'b0;
        end

        dec_floor = EW'(sustain_level) + EW'(decay_rate);
        if (env_ext <= dec_floor) begin
            dec_env  = sustain_level;
            dec_done = 1'b1;
        end else begin
            dec_env  = env_q - C_WIDTH'(decay_rate);
            dec_done = 1'b0;
        end

`ifdef ENVGEN_EXP_RELEASE_EN
        rel_step = (env_ext >> release_rate[3:0]) + EW'(1);
`else
        rel_step = EW'(release_rate);
`endif
        if (env_ext <= rel_step) begin
            rel_env  = '0;
            rel_done = 1'b1;
        end else begin
            rel_env  = env_q - rel_step[C_WIDTH-1:0];
            rel_done = 1'b0;
        end
    end

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        gate_d  = gate_q;
        valid_d = 1'b0;

        if (tick) begin
            valid_d = 1'b1;
            gate_d  = gate;

            if (rise) begin
                // Retrigger continues from the present level to avoid a click.
                env_d   = atk_env;
                state_d = atk_done ? S_DECAY : S_ATTACK;
            end else if (fall && (state_q == S_ATTACK || state_q == S_DECAY ||
                                  state_q == S_SUSTAIN)) begin
                env_d   = rel_env;
                state_d = rel_done ? S_IDLE : S_RELEASE;
            end else begin
                case (state_q)
                    S_ATTACK: begin
                        env_d   = atk_env;
                        state_d = atk_done ? S_DECAY : S_ATTACK;
                    end
                    S_DECAY: begin
                        env_d   = dec_env;
                        state_d = dec_done ? S_SUSTAIN : S_DECAY;
                    end
                    S_SUSTAIN: begin
                        env_d   = sustain_level;
                        state_d = S_SUSTAIN;
                    end
                    S_RELEASE: begin
                        env_d   = rel_env;
                        state_d = rel_done ? S_IDLE : S_RELEASE;
                    end
                    default: begin
                        env_d   = '0;
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            env_q   <= '0;
            valid_q <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            valid_q <= valid_d;
            gate_q  <= gate_d;
        end
    end

    assign env_out   = env_q;
    assign env_valid = valid_q;
    assign state     = state_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/envelope_gen.md
Name: envelope_gen

Overview:
- ADSR envelope generator; produces the per-sample amplitude word fed to the multiplier's b operand (oscillator sample on a).
- Advances one step per sample-rate tick.
- Pulses env_valid with each new value so it can drive the multiplier's trigger directly.
- One instance per voice, in the ctl_clk domain.

Parameters:
- C_WIDTH, 16, envelope amplitude width; full scale = 2^C_WIDTH-1.
- C_RATE_WIDTH, 16, width of attack/decay/release step inputs; must be <= C_WIDTH.

Ports:
- ctl_clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  sample-rate enable; one-cycle pulse.
- gate  input  1  note on (1) / off (0); sampled only on tick cycles.
- attack_rate  input  C_RATE_WIDTH  amplitude added per tick in ATTACK.
- decay_rate  input  C_RATE_WIDTH  amplitude subtracted per tick in DECAY.
- sustain_level  input  C_WIDTH  SUSTAIN plateau level.
- release_rate  input  C_RATE_WIDTH  amplitude subtracted per tick in RELEASE.
- env_out  output  C_WIDTH  current envelope value (registered).
- env_valid  output  1  one-cycle pulse; env_out updated this cycle.
- state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, reset=0): env_out=0, env_valid=0, state=IDLE, busy=0, gate_q=0. Reset mid-envelope aborts immediately; no release tail.
- Non-tick cycles: all registers hold; env_valid=0.
- Tick cycle: gate_q<=gate. rise = gate & ~gate_q; fall = ~gate & gate_q. Gate pulses shorter than one tick period are lost (by design).
- Latency: env_out, state and env_valid all update on the rising edge where tick=1. env_valid is high for exactly the following cycle.
- env_valid pulses on every tick, including IDLE (env_out=0). The multiplier therefore always receives a fresh operand per sample.
- Priority per tick: rise > fall > normal state step.
- rise (from any state, incl. RELEASE): state=ATTACK; first step applied from the current env_out (no reset to 0, no click).
- fall from ATTACK/DECAY/SUSTAIN: state=RELEASE; first release step applied on the same tick.
- fall in IDLE/RELEASE: no effect beyond the normal step.
- ATTACK: sum = env_out + attack_rate at C_WIDTH+1 bits. If sum >= full scale: env_out=full scale, state=DECAY (same edge). Otherwise env_out=sum.
- DECAY: if env_out <= sustain_level + decay_rate (compare at C_WIDTH+1 bits): env_out=sustain_level, state=SUSTAIN. Otherwise env_out -= decay_rate.
- SUSTAIN: env_out=sustain_level each tick, so it tracks live changes to sustain_level.
- RELEASE: if env_out <= step: env_out=0, state=IDLE. Otherwise env_out -= step. Linear mode: step = release_rate.
- Zero rates: attack_rate=0 stalls in ATTACK; decay_rate=0 stalls in DECAY; release_rate=0 stalls in RELEASE. Rate inputs may change at any time; the new value applies from the next tick.
- sustain_level >= full scale: DECAY exits to SUSTAIN on its first tick at full scale.
- sustain_level=0: SUSTAIN holds 0 while busy=1 until gate falls.
- No arithmetic wraps; all add/subtract paths saturate.

Optional Feature:
- Macro: ENVGEN_EXP_RELEASE_EN.
- Defined: RELEASE uses exponential decay, step = (env_out >> release_rate[3:0]) + 1. release_rate[3:0]=0 gives a one-tick release to 0. Upper release_rate bits are ignored.
- Not defined: linear release, step = release_rate. ATTACK/DECAY are identical in both builds.

Test Plan (C_WIDTH=8, C_RATE_WIDTH=8, tick every 4 clocks):
- Reset release, gate=0, 3 ticks -> env_out=0x00, state=0, env_valid pulses 3 times, each 1 cycle wide.
- attack=0x40, decay=0x20, sustain=0x90, gate rises -> env_out 0x40,0x80,0xC0,0xFF (state->DECAY), then 0xDF,0xBF,0x9F,0x90 (state->SUSTAIN).
- In SUSTAIN, change sustain to 0x70 -> next tick env_out=0x70; then gate falls, release=0x50 -> 0x20, then 0x00 with state=IDLE, busy=0.
- Retrigger: gate falls at 0xC0 (release=0x10) -> 0xB0; gate rises -> ATTACK from 0xB0, next value 0xF0, then 0xFF.
- Assert reset=0 mid-DECAY between clock edges -> env_out=0, state=0, env_valid=0 immediately, without waiting for a clock edge.
- ENVGEN_EXP_RELEASE_EN defined, release_rate=1, from 0x80 -> 0x3F,0x1F,0x0F,0x07,0x03,0x01,0x00 then IDLE. Same stimulus without the macro -> 0x7F,0x7E,... (linear).
